// File: rtl/squ_ker_provider.sv
// Kernel provider for the squeeze convolution engine: buffers one layer of paired
// 3x3/1x1 kernel words and replays them on request in word, kernel, pixel order.
module squ_ker_provider #(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [9:0]        no_of_squ_kernals_i,
    input  logic [5:0]        squ_ker_words_i,
    input  logic [6:0]        squ_layer_dimension_i,
    input  logic [127:0]      ker_wr_data_i,
    input  logic              ker_wr_en_i,
    input  logic              squ_ker_req_i,
    output logic              squ_ker_ready_o,
    output logic [63:0]       squ_3x3_ker_o,
    output logic [63:0]       squ_1x1_ker_o,
    output logic [ADDR_W:0]   load_count_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              cfg_err_o
);
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SERVE, ST_DONE} state_t;

    localparam logic [16:0] RAM_WORDS = 17'(2**ADDR_W);

    logic [127:0]      ram [2**ADDR_W];

    state_t            state_q;
    logic [9:0]        k_q;
    logic [5:0]        w_q;
    logic [6:0]        d_q;
    logic [16:0]       total_q;
    logic [ADDR_W:0]   load_cnt_q;
    logic [5:0]        word_q;
    logic [9:0]        ker_q;
    logic [6:0]        col_q;
    logic [6:0]        row_q;
    logic [ADDR_W-1:0] base_q;
    logic              ready_q;
    logic              done_q;
    logic              err_q;
    logic [63:0]       k3_q;
    logic [63:0]       k1_q;

    logic [16:0]       total_d;
    logic [ADDR_W-1:0] rd_addr_d;
    logic [127:0]      rd_data_d;
    logic              wr_acc_d;
    logic              req_acc_d;
    logic              word_last_d, ker_last_d, col_last_d, row_last_d;

    assign total_d   = (17'(no_of_squ_kernals_i) + 17'd1) * (17'(squ_ker_words_i) + 17'd1);
    assign rd_addr_d = base_q + ADDR_W'(word_q);
    assign rd_data_d = ram[rd_addr_d];
    assign wr_acc_d  = (state_q == ST_LOAD) && ker_wr_en_i && !start_i && !rst_i
                       && (17'(load_cnt_q) < total_q);
    assign req_acc_d = (state_q == ST_SERVE) && ready_q && squ_ker_req_i && !start_i;

    assign word_last_d = (word_q == w_q);
    assign ker_last_d  = (ker_q == k_q);
    assign col_last_d  = (col_q == d_q);
    assign row_last_d  = (row_q == d_q);

    always_ff @(posedge clk_i) begin
        if (wr_acc_d) ram[load_cnt_q[ADDR_W-1:0]] <= ker_wr_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            w_q        <= '0;
            d_q        <= '0;
            total_q    <= '0;
            load_cnt_q <= '0;
            word_q     <= '0;
            ker_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            base_q     <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            k3_q       <= '0;
            k1_q       <= '0;
        end else if (start_i) begin
            // Kernel data outputs deliberately hold across a restart.
            k_q        <= no_of_squ_kernals_i;
            w_q        <= squ_ker_words_i;
            d_q        <= squ_layer_dimension_i;
            total_q    <= total_d;
            load_cnt_q <= '0;
            word_q     <= '0;
            ker_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            base_q     <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= (total_d > RAM_WORDS);
            state_q    <= (total_d > RAM_WORDS) ? ST_IDLE : ST_LOAD;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_LOAD: begin
                    if (wr_acc_d) begin
                        load_cnt_q <= load_cnt_q + 1'b1;
                        if (17'(load_cnt_q) + 17'd1 == total_q) begin
                            state_q <= ST_SERVE;
                            ready_q <= 1'b1;
                        end
                    end
                end
                ST_SERVE: begin
                    if (req_acc_d) begin
                        k3_q <= rd_data_d[127:64];
                        k1_q <= rd_data_d[63:0];
                        // Address walk uses a running kernel base instead of ker*(W+1).
                        if (word_last_d) begin
                            word_q <= '0;
                            if (ker_last_d) begin
                                ker_q  <= '0;
                                base_q <= '0;
                                if (col_last_d) begin
                                    col_q <= '0;
                                    row_q <= row_q + 1'b1;
                                end else begin
                                    col_q <= col_q + 1'b1;
                                end
                            end else begin
                                ker_q  <= ker_q + 1'b1;
                                base_q <= base_q + ADDR_W'(w_q) + ADDR_W'(1);
                            end
                        end else begin
                            word_q <= word_q + 1'b1;
                        end
                        if (word_last_d && ker_last_d && col_last_d && row_last_d) begin
                            state_q <= ST_DONE;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign squ_ker_ready_o = ready_q;
    assign squ_3x3_ker_o   = k3_q;
    assign squ_1x1_ker_o   = k1_q;
    assign load_count_o    = load_cnt_q;
    assign busy_o          = (state_q != ST_IDLE);
    assign done_o          = done_q;
    assign cfg_err_o       = err_q;
endmodule

// File: tb/tb_squ_ker_provider.sv
// Directed bench for squ_ker_provider: a vector table for the basic load/serve
// flow plus hand-written sequences for multi-cycle corner cases.
module tb_squ_ker_provider;
    logic         clk = 1'b0;
    logic         rst, start, wr_en, req;
    logic [9:0]   k_cfg;
    logic [5:0]   w_cfg;
    logic [6:0]   d_cfg;
    logic [127:0] wr_data;
    logic         ready, busy, done, cfg_err;
    logic [63:0]  k3, k1;
    logic [10:0]  lc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    squ_ker_provider #(.ADDR_W(10)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .no_of_squ_kernals_i(k_cfg), .squ_ker_words_i(w_cfg), .squ_layer_dimension_i(d_cfg),
        .ker_wr_data_i(wr_data), .ker_wr_en_i(wr_en), .squ_ker_req_i(req),
        .squ_ker_ready_o(ready), .squ_3x3_ker_o(k3), .squ_1x1_ker_o(k1),
        .load_count_o(lc), .busy_o(busy), .done_o(done), .cfg_err_o(cfg_err)
    );

    typedef struct {
        logic         st, wr, rq;
        logic [127:0] wd;
        logic         e_rdy, e_done, e_busy;
        logic [10:0]  e_lc;
        logic [127:0] e_data;
    } vec_t;

    vec_t tbl[11];

    function automatic logic [127:0] kw(input logic [7:0] tag, input int i);
        return {tag, 24'h0, 32'(i), tag ^ 8'hFF, 24'h0, 32'(i)};
    endfunction

    function automatic vec_t mkv(input logic st, input logic wr, input logic rq,
                                 input logic [127:0] wd, input logic e_rdy, input logic e_done,
                                 input logic e_busy, input logic [10:0] e_lc,
                                 input logic [127:0] e_data);
        vec_t v;
        v.st = st; v.wr = wr; v.rq = rq; v.wd = wd;
        v.e_rdy = e_rdy; v.e_done = e_done; v.e_busy = e_busy;
        v.e_lc = e_lc; v.e_data = e_data;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic st, input logic wr, input logic [127:0] wd, input logic rq);
        start = st; wr_en = wr; wr_data = wd; req = rq;
        @(posedge clk);
        #1;
        start = 1'b0; wr_en = 1'b0; req = 1'b0;
    endtask

    task automatic cfg(input int k, input int w, input int d);
        k_cfg = 10'(k); w_cfg = 6'(w); d_cfg = 7'(d);
    endtask

    task automatic load4(input logic [7:0] tag);
        cyc(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, kw(tag, i), 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; wr_en = 1'b0; req = 1'b0; wr_data = '0;
        cfg(1, 1, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {ready, done, busy, cfg_err, lc, k3, k1}, '0);
        rst = 1'b0;

        tbl[0]  = mkv(1, 0, 0, '0,          0, 0, 1, 0, '0);
        tbl[1]  = mkv(0, 1, 0, kw(8'hA0,0), 0, 0, 1, 1, '0);
        tbl[2]  = mkv(0, 1, 0, kw(8'hA0,1), 0, 0, 1, 2, '0);
        tbl[3]  = mkv(0, 1, 0, kw(8'hA0,2), 0, 0, 1, 3, '0);
        tbl[4]  = mkv(0, 0, 1, '0,          0, 0, 1, 3, '0);
        tbl[5]  = mkv(0, 1, 0, kw(8'hA0,3), 1, 0, 1, 4, '0);
        tbl[6]  = mkv(0, 0, 1, '0,          1, 0, 1, 4, kw(8'hA0,0));
        tbl[7]  = mkv(0, 0, 1, '0,          1, 0, 1, 4, kw(8'hA0,1));
        tbl[8]  = mkv(0, 0, 1, '0,          1, 0, 1, 4, kw(8'hA0,2));
        tbl[9]  = mkv(0, 0, 1, '0,          0, 1, 1, 4, kw(8'hA0,3));
        tbl[10] = mkv(0, 0, 0, '0,          0, 0, 0, 4, kw(8'hA0,3));

        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].st, tbl[i].wr, tbl[i].wd, tbl[i].rq);
            chk($sformatf("vec%0d_ctrl", i), {ready, done, busy, lc},
                {tbl[i].e_rdy, tbl[i].e_done, tbl[i].e_busy, tbl[i].e_lc});
            chk($sformatf("vec%0d_data", i), {k3, k1}, tbl[i].e_data);
        end

        // D=1: four output pixels, 16 requests
        cfg(1, 1, 1);
        load4(8'hA0);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b0, '0, 1'b1);
            chk($sformatf("d1_data%0d", i), {k3, k1}, kw(8'hA0, i % 4));
            chk($sformatf("d1_ctrl%0d", i), {ready, done}, (i == 15) ? 2'b01 : 2'b10);
        end
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("d1_after", {busy, ready, done}, 3'b000);

        // requests every third cycle; data appears next cycle and holds
        cfg(1, 1, 0);
        load4(8'hC0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, '0, 1'b1);
            chk($sformatf("gap_data%0d", i), {k3, k1}, kw(8'hC0, i));
            chk($sformatf("gap_done%0d", i), done, (i == 3));
            for (int g = 0; g < 2; g++) begin
                cyc(1'b0, 1'b0, '0, 1'b0);
                chk($sformatf("gap_hold%0d_%0d", i, g), {k3, k1}, kw(8'hC0, i));
            end
        end

        // oversized configuration
        cfg(1023, 63, 0);
        cyc(1'b1, 1'b0, '0, 1'b0);
        chk("err_set", {cfg_err, busy, ready}, 3'b100);
        cyc(1'b0, 1'b1, kw(8'hEE, 0), 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("err_idle", {cfg_err, busy, ready, lc}, {3'b100, 11'd0});

        // minimal legal config clears the error: one word, one request
        cfg(0, 0, 0);
        cyc(1'b1, 1'b0, '0, 1'b0);
        chk("err_clear", {cfg_err, busy, ready}, 3'b010);
        cyc(1'b0, 1'b1, kw(8'hE0, 0), 1'b0);
        chk("min_ready", {ready, lc}, {1'b1, 11'd1});
        cyc(1'b0, 1'b1, kw(8'hE0, 1), 1'b0);
        chk("min_sat", lc, 11'd1);
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("min_data", {k3, k1}, kw(8'hE0, 0));
        chk("min_done", {ready, done, busy}, 3'b011);

        // restart mid-SERVE, start wins over a simultaneous request
        cfg(1, 1, 0);
        load4(8'hA0);
        cyc(1'b0, 1'b0, '0, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("mid_pre", {k3, k1}, kw(8'hA0, 1));
        cyc(1'b1, 1'b0, '0, 1'b1);
        chk("mid_start", {ready, busy, lc}, {2'b01, 11'd0});
        chk("mid_hold", {k3, k1}, kw(8'hA0, 1));
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, kw(8'hB0, i), 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("mid_b0", {k3, k1}, kw(8'hB0, 0));
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("mid_b1", {k3, k1}, kw(8'hB0, 1));

        // reset during LOAD
        cyc(1'b1, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b1, kw(8'hD0, 0), 1'b0);
        cyc(1'b0, 1'b1, kw(8'hD0, 1), 1'b0);
        chk("rst_pre_lc", lc, 11'd2);
        rst = 1'b1;
        cyc(1'b0, 1'b0, '0, 1'b0);
        rst = 1'b0;
        chk("rst_mid_load", {busy, ready, lc}, {2'b00, 11'd0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
